ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable). It shares the open-collector ps_clk/ps_data lines with the existing PS/2 scan-code receiver, and drives each line only through an active-high pull-low enable. The board top level muxes its line enables and blanks the receiver while tx_busy=1.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles ps_clk is held low before the start bit (120 us at 50 MHz; minimum legal 100 us).
TIMEOUT_CYCLES, 750000, watchdog limit in clk cycles (15 ms at 50 MHz); used only with PS2_TX_WATCHDOG_EN.
SYNC_STAGES, 2, synchronizer flops on ps_clk_in and ps_data_in; legal range 2..3.

Ports:
clk  input  1  system clock, 50 MHz nominal
resetn  input  1  synchronous reset, active-low
tx_data  input  8  command byte
tx_valid  input  1  request; byte accepted on the clk edge where tx_valid=1 and tx_ready=1
tx_ready  output  1  high only in IDLE
tx_busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse: frame completed with ack
tx_error  output  1  one-cycle pulse: no ack (or timeout)
ps_clk_in  input  1  raw PS/2 clock line
ps_data_in  input  1  raw PS/2 data line
ps_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release
ps_data_oe  output  1  1 = pull PS/2 data low; 0 = release

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; tx_ready=1; tx_busy=0; tx_done=0; tx_error=0; ps_clk_oe=0; ps_data_oe=0.
  - Synchronizers preset to 1; all counters cleared.
  - Reset mid-frame releases both lines on the next edge.
- Input sampling: ps_clk_in and ps_data_in pass through SYNC_STAGES flops. fall = previous synced clk 1 and current 0. All protocol decisions use only the synced signals and fall.
- Frame latch: on acceptance, latch shift[8:0] = {odd_parity, tx_data}, where odd_parity = ~^tx_data. Clear bit counter bitcnt (4 bits).
- States:
  - IDLE: both oe=0. Acceptance -> INHIBIT.
  - INHIBIT: ps_clk_oe=1. Counts INHIBIT_CYCLES clks. On the last count, ps_data_oe=1 (start bit) -> REL_CLK.
  - REL_CLK: ps_clk_oe=0; ps_data_oe stays 1 -> DATA.
  - DATA: on each fall, ps_data_oe = ~shift[0], shift >>= 1, bitcnt++.
    - Falls 1..8 present data bits LSB first; fall 9 presents parity.
    - At bitcnt=9 -> STOP.
  - STOP: on the next fall (fall 10), ps_data_oe=0 (stop bit = released line) -> ACK.
  - ACK: on the next fall (fall 11), sample synced data.
    - 0 -> WAIT_IDLE with ack_ok=1.
    - 1 -> WAIT_IDLE with ack_ok=0.
  - WAIT_IDLE: wait until synced clk=1 and synced data=1. Then pulse tx_done (ack_ok=1) or tx_error (ack_ok=0) for exactly one cycle -> IDLE.
- Simultaneous events: tx_valid in the same cycle as tx_done/tx_error is not accepted, because tx_ready is 0 that cycle. The earliest acceptance is the cycle after return to IDLE.
- The device may stretch the clock arbitrarily; there is no timing requirement on ps_clk period.
- tx_data is ignored except at acceptance.
- Outputs are registered; no combinational path from any input to any output.

Optional Feature:
PS2_TX_WATCHDOG_EN:
- Defined:
  - A counter starts at acceptance and clears on return to IDLE.
  - If it reaches TIMEOUT_CYCLES in any state from REL_CLK through WAIT_IDLE, release both oe next cycle, pulse tx_error, and go -> IDLE.
  - Timeout takes priority over a fall in the same cycle.
- Not defined: no counter is built; the FSM waits indefinitely for device clocks.

Test Plan:
- Reset: hold resetn=0 for 3 clks mid-DATA -> ps_clk_oe=0, ps_data_oe=0, tx_ready=1, tx_busy=0 on the edge after reset.
- Send 0xED with device model clocking at 12.5 kHz and acking -> ps_clk_oe high for exactly 6000 clks; device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; one tx_done pulse; tx_error stays 0.
- Send 0xF4 -> device sees data 0,0,1,0,1,1,1,1 and parity 0; tx_done pulse; tx_ready returns 1 only after both lines are high.
- Device withholds ack (data high at fall 11) -> one tx_error pulse; no tx_done; IDLE afterwards.
- tx_valid held high continuously with 0x01, then 0x02 -> exactly two frames, back to back; the second starts the cycle after the first's tx_done pulse.
- With PS2_TX_WATCHDOG_EN, device stops after fall 5 -> tx_error pulse at 750000 clks after acceptance; both oe=0. Without the macro -> FSM stays in DATA and tx_busy stays 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-collector pull-low enables.
// Optional watchdog: define PS2_TX_WATCHDOG_EN to abort a stalled frame after TIMEOUT_CYCLES.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps_clk_in,
    input  logic       ps_data_in,
    output logic       ps_clk_oe,
    output logic       ps_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REL_CLK, DATA, STOP, ACK, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [8:0]             shift_q, shift_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
    logic                   ack_ok_q, ack_ok_d;
    logic                   ready_q, ready_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                   clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic                   clk_s, data_s, fall, accept, timeout;

    assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps_clk_in};
    assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps_data_in};
    assign clk_s       = clk_sync_q[SYNC_STAGES-1];
    assign data_s      = data_sync_q[SYNC_STAGES-1];
    assign clk_prev_d  = clk_s;
    assign fall        = clk_prev_q & ~clk_s;
    assign accept      = tx_valid & ready_q;

    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps_clk_oe  = clk_oe_q;
    assign ps_data_oe = data_oe_q;

`ifdef PS2_TX_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_cnt_d = (state_q == IDLE) ? '0 :
                      (wd_cnt_q >= TW'(TIMEOUT_CYCLES)) ? wd_cnt_q : wd_cnt_q + TW'(1);
    assign timeout  = (state_q inside {REL_CLK, DATA, STOP, ACK, WAIT_IDLE}) &&
                      (wd_cnt_q >= TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: runs from acceptance, held at zero while idle
    always_ff @(posedge clk) begin
        wd_cnt_q <= !resetn ? '0 : wd_cnt_d;
    end
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES > 0;
    assign timeout        = 1'b0;
`endif

    // Frame sequencing: next state, shift register and registered line/handshake outputs
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        inh_cnt_d = inh_cnt_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                clk_oe_d  = accept;
                data_oe_d = 1'b0;
                ready_d   = ~accept;
                if (accept) begin
                    state_d   = INHIBIT;
                    shift_d   = {~^tx_data, tx_data};
                    bitcnt_d  = '0;
                    inh_cnt_d = '0;
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + IW'(1);
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) begin
                    data_oe_d = 1'b1;
                    state_d   = REL_CLK;
                end
            end
            REL_CLK: begin
                clk_oe_d = 1'b0;
                state_d  = DATA;
            end
            DATA: if (fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b0, shift_q[8:1]};
                bitcnt_d  = bitcnt_q + 4'd1;
                state_d   = (bitcnt_q == 4'd8) ? STOP : DATA;
            end
            STOP: if (fall) begin
                data_oe_d = 1'b0;
                state_d   = ACK;
            end
            ACK: if (fall) begin
                ack_ok_d = ~data_s;
                state_d  = WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                done_d  = ack_ok_q;
                error_d = ~ack_ok_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
        end
        busy_d = ~ready_d;
    end

    // State, synchronizers and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            inh_cnt_q   <= '0;
            ack_ok_q    <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            inh_cnt_q   <= inh_cnt_d;
            ack_ok_q    <= ack_ok_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
        end
    end
endmodule
